// File: rtl/wb_commit.sv
// rtl/wb_commit.sv - MEM/WB result pipeline, 32x32 register file and forwarding read ports
//
// Takes the EX result triple through the MEM and WB pipeline registers and
// commits it into the general register file. Two decode read ports see the
// newest value of any register by forwarding from live EX, MEM and WB.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ex_wd_i/ex_wreg_i/ex_wdata_i  EX stage result (destination, enable, data)
//   stall_i                       hold MEM, inject a bubble into WB
//   flush_i                       discard MEM and WB contents
//   re1_i/raddr1_i -> rdata1_o    read port 1 (combinational)
//   re2_i/raddr2_i -> rdata2_o    read port 2 (combinational)
//   wb_wd_o/wb_wreg_o/wb_wdata_o  WB stage contents (commit trace)

module wb_commit #(
    parameter int REG_NUM = 32,
    parameter int REG_AW  = 5,
    parameter int DW      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] ex_wd_i,
    input  logic              ex_wreg_i,
    input  logic [DW-1:0]     ex_wdata_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              re1_i,
    input  logic [REG_AW-1:0] raddr1_i,
    output logic [DW-1:0]     rdata1_o,
    input  logic              re2_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DW-1:0]     rdata2_o,
    output logic [REG_AW-1:0] wb_wd_o,
    output logic              wb_wreg_o,
    output logic [DW-1:0]     wb_wdata_o
);

    logic [REG_AW-1:0] mem_wd;
    logic              mem_wreg;
    logic [DW-1:0]     mem_wdata;
    logic [REG_AW-1:0] wb_wd;
    logic              wb_wreg;
    logic [DW-1:0]     wb_wdata;

    logic [DW-1:0] regs [REG_NUM];

    // Pipeline registers: rst > flush > stall > normal advance.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            wb_wd     <= '0;
            wb_wreg   <= 1'b0;
            wb_wdata  <= '0;
        end else if (stall_i) begin
            // MEM holds; WB takes a bubble so the held entry is not committed twice.
            wb_wd    <= '0;
            wb_wreg  <= 1'b0;
            wb_wdata <= '0;
        end else begin
            mem_wd    <= ex_wd_i;
            mem_wreg  <= ex_wreg_i;
            mem_wdata <= ex_wdata_i;
            wb_wd     <= mem_wd;
            wb_wreg   <= mem_wreg;
            wb_wdata  <= mem_wdata;
        end
    end

    // Array commit. The current WB entry still lands on flush and stall edges;
    // only reset suppresses it. r0 is hard-wired to zero and never written.
    always_ff @(posedge clk) begin
        if (!rst && wb_wreg && (wb_wd != '0)) begin
            regs[wb_wd] <= wb_wdata;
        end
    end

    // Read port 1: youngest in-flight producer wins. The re check comes before
    // any address compare so an unused port cannot leak unknown inputs.
    always_comb begin
        rdata1_o = '0;
        if (rst || !re1_i || (raddr1_i == '0)) begin
            rdata1_o = '0;
        end else if (ex_wreg_i && (ex_wd_i == raddr1_i)) begin
            rdata1_o = ex_wdata_i;
        end else if (mem_wreg && (mem_wd == raddr1_i)) begin
            rdata1_o = mem_wdata;
        end else if (wb_wreg && (wb_wd == raddr1_i)) begin
            rdata1_o = wb_wdata;
        end else begin
            rdata1_o = regs[raddr1_i];
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        rdata2_o = '0;
        if (rst || !re2_i || (raddr2_i == '0)) begin
            rdata2_o = '0;
        end else if (ex_wreg_i && (ex_wd_i == raddr2_i)) begin
            rdata2_o = ex_wdata_i;
        end else if (mem_wreg && (mem_wd == raddr2_i)) begin
            rdata2_o = mem_wdata;
        end else if (wb_wreg && (wb_wd == raddr2_i)) begin
            rdata2_o = wb_wdata;
        end else begin
            rdata2_o = regs[raddr2_i];
        end
    end

    assign wb_wd_o    = wb_wd;
    assign wb_wreg_o  = wb_wreg;
    assign wb_wdata_o = wb_wdata;

endmodule
